// File: rtl/oh_inv_filter_if.sv
// Bundle of the filter's data-side signals: enable, polarity mask, raw inputs,
// and the filtered outputs with their change pulses.
interface oh_inv_filter_if #(
    parameter int N = 8
);
    logic         en;
    logic [N-1:0] inv;
    logic [N-1:0] a;
    logic [N-1:0] z;
    logic [N-1:0] chg;

    modport master (output en, output inv, output a, input z, input chg);
    modport slave  (input en, input inv, input a, output z, output chg);
endinterface

// File: rtl/oh_inv_filter.sv
// N-bit programmable-polarity inverter bank with an optional 2-flop input
// synchroniser and a per-bit stability filter that emits a change pulse.
module oh_inv_filter #(
    parameter int           N      = 8,
    parameter int           DEPTH  = 4,
    parameter int           SYNC   = 1,
    parameter logic [N-1:0] RSTVAL = {N{1'b1}},
    parameter               PROP   = "DEFAULT"
) (
    input  logic            clk,
    input  logic            reset,
    oh_inv_filter_if.slave  bus
);

    localparam int            CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [N-1:0] as_w;
    logic [N-1:0] cand;

    generate
        if (SYNC != 0) begin : g_sync
            logic [N-1:0] s1_reg;
            logic [N-1:0] s2_reg;

            // Free-running: the synchroniser keeps sampling even while en is low.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_reg <= '0;
                    s2_reg <= '0;
                end else begin
                    s1_reg <= bus.a;
                    s2_reg <= s1_reg;
                end
            end

            assign as_w = s2_reg;
        end else begin : g_nosync
            assign as_w = bus.a;
        end
    endgenerate

    assign cand = as_w ^ bus.inv;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic          z_reg;
            logic          chg_reg;

            // The count only advances on consecutive enabled mismatches; any
            // agreement with z clears it, so short glitches never reach z.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                    z_reg   <= RSTVAL[gi];
                    chg_reg <= 1'b0;
                end else if (!bus.en) begin
                    chg_reg <= 1'b0;
                end else if (cand[gi] == z_reg) begin
                    cnt_reg <= '0;
                    chg_reg <= 1'b0;
                end else if (cnt_reg == LAST) begin
                    z_reg   <= cand[gi];
                    cnt_reg <= '0;
                    chg_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                    chg_reg <= 1'b0;
                end
            end

            assign bus.z[gi]   = z_reg;
            assign bus.chg[gi] = chg_reg;
        end
    endgenerate

endmodule
